// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: byte-stream input and 512-bit block output of the SHA-256 padder.
// master: message source / SHA-256 core side (drives i_valid, i_data, i_last, o_ready).
// slave:  the padder (drives i_ready, o_valid, o_block, o_first, o_final, o_len_err, o_key_err).
`timescale 1ns/1ps
interface sha256_msg_padder_if;
    logic         i_valid;
    logic         i_ready;
    logic [7:0]   i_data;
    logic         i_last;
    logic         o_valid;
    logic         o_ready;
    logic [511:0] o_block;
    logic         o_first;
    logic         o_final;
    logic         o_len_err;
    logic         o_key_err;
    modport master (
        output i_valid, i_data, i_last, o_ready,
        input  i_ready, o_valid, o_block, o_first, o_final, o_len_err, o_key_err
    );
    modport slave (
        input  i_valid, i_data, i_last, o_ready,
        output i_ready, o_valid, o_block, o_first, o_final, o_len_err, o_key_err
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 SHA-256 padding of a byte stream into big-endian 512-bit blocks.
// Ports: clk (rising edge), rst_n (async active-low), bus (sha256_msg_padder_if.slave):
//   i_valid/i_ready/i_data/i_last byte input, o_valid/o_ready/o_block block output,
//   o_first (load IV), o_final (last block), o_len_err (length saturated), o_key_err.
// Optional: define HASH160_PUBKEY_CHECK_EN to flag messages that are not SEC public keys
// on o_key_err; otherwise o_key_err is tied to 0.
`timescale 1ns/1ps
module sha256_msg_padder #(
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic rst_n,
    sha256_msg_padder_if.slave bus
);
    typedef enum logic [1:0] {S_FILL, S_EMIT, S_EMIT_TAIL} state_t;
    state_t state;
    logic [7:0] blk [64];
    logic [5:0] idx;
    logic [LEN_W-1:0] len, len_nx;
    logic len_err, first, tail, tail_lead, rdy, vld, first_o, final_o;
    logic acc, xfer;
    logic [6:0] k;
    logic [63:0] bl, bl_nx;
    logic [511:0] flat;

    assign acc = (state == S_FILL) && bus.i_valid;
    assign xfer = (state != S_FILL) && bus.o_ready;
    assign k = {1'b0, idx} + 7'd1;
    assign len_nx = &len ? len : len + LEN_W'(1);
    assign bl = {{(61-LEN_W){1'b0}}, len, 3'b000};
    assign bl_nx = {{(61-LEN_W){1'b0}}, len_nx, 3'b000};

    for (genvar g = 0; g < 64; g++) begin : g_out
        assign flat[511-8*g -: 8] = blk[g];
    end

    assign bus.i_ready = rdy;
    assign bus.o_valid = vld;
    assign bus.o_block = flat;
    assign bus.o_first = first_o;
    assign bus.o_final = final_o;
    assign bus.o_len_err = len_err;

    // The buffer is cleared whenever a block leaves, so padding only has to place
    // the 0x80 marker and the length; everything in between is already zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
            idx <= '0;
            len <= '0;
            len_err <= 1'b0;
            first <= 1'b1;
            tail <= 1'b0;
            tail_lead <= 1'b0;
            rdy <= 1'b1;
            vld <= 1'b0;
            first_o <= 1'b0;
            final_o <= 1'b0;
            for (int j = 0; j < 64; j++) blk[j] <= '0;
        end else if (acc) begin
            blk[idx] <= bus.i_data;
            len <= len_nx;
            if (&len) len_err <= 1'b1;
            if (bus.i_last && k <= 7'd63) blk[k[5:0]] <= 8'h80;
            if (bus.i_last && k <= 7'd55)
                for (int j = 0; j < 8; j++) blk[56+j] <= bl_nx[63-8*j -: 8];
            if (bus.i_last || &idx) begin
                state <= S_EMIT;
                vld <= 1'b1;
                rdy <= 1'b0;
                first_o <= first;
                first <= 1'b0;
                final_o <= bus.i_last && k <= 7'd55;
                tail <= bus.i_last && k >= 7'd56;
                tail_lead <= bus.i_last && k == 7'd64;
            end else begin
                idx <= idx + 6'd1;
            end
        end else if (xfer) begin
            if (state == S_EMIT && tail) begin
                state <= S_EMIT_TAIL;
                tail <= 1'b0;
                first_o <= 1'b0;
                final_o <= 1'b1;
                blk[0] <= tail_lead ? 8'h80 : 8'h00;
                for (int j = 1; j < 56; j++) blk[j] <= '0;
                for (int j = 0; j < 8; j++) blk[56+j] <= bl[63-8*j -: 8];
            end else begin
                state <= S_FILL;
                idx <= '0;
                vld <= 1'b0;
                rdy <= 1'b1;
                first_o <= 1'b0;
                final_o <= 1'b0;
                for (int j = 0; j < 64; j++) blk[j] <= '0;
                if (final_o) begin
                    len <= '0;
                    len_err <= 1'b0;
                    first <= 1'b1;
                end
            end
        end
    end

`ifdef HASH160_PUBKEY_CHECK_EN
    logic t33, t65, key_pend, key_o, c33, c65, bad_now;

    // The header byte is judged as it arrives; for later bytes the captured verdict is used.
    assign c33 = (len == '0) ? (bus.i_data == 8'h02 || bus.i_data == 8'h03) : t33;
    assign c65 = (len == '0) ? (bus.i_data == 8'h04) : t65;
    assign bad_now = !((len_nx == LEN_W'(33) && c33) || (len_nx == LEN_W'(65) && c65));
    assign bus.o_key_err = key_o;

    // A verdict for a message whose final block is a tail waits in key_pend until the tail is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t33 <= 1'b0;
            t65 <= 1'b0;
            key_pend <= 1'b0;
            key_o <= 1'b0;
        end else if (acc) begin
            if (len == '0) begin
                t33 <= c33;
                t65 <= c65;
            end
            if (bus.i_last) begin
                key_pend <= bad_now;
                key_o <= bad_now && k <= 7'd55;
            end
        end else if (xfer) begin
            key_o <= (state == S_EMIT) && tail && key_pend;
        end
    end
`else
    assign bus.o_key_err = 1'b0;
`endif
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed checks of the SHA-256 message padder (LEN_W=8 so overflow is reachable).
`timescale 1ns/1ps
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

`ifdef HASH160_PUBKEY_CHECK_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif
    localparam logic [511:0] ABC = {32'h61626380, 416'h0, 64'h18};

    typedef struct packed {
        logic [511:0] blk;
        logic first;
        logic fin;
        logic lerr;
        logic kerr;
    } rec_t;
    rec_t q[$];

    sha256_msg_padder_if bus();
    sha256_msg_padder #(.LEN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && bus.o_valid && bus.o_ready)
            q.push_back({bus.o_block, bus.o_first, bus.o_final, bus.o_len_err, bus.o_key_err});

    task automatic send_bytes(input logic [7:0] m[$], input bit with_last);
        for (int i = 0; i < m.size(); i++) begin
            int t;
            t = 0;
            bus.i_valid = 1'b1;
            bus.i_data = m[i];
            bus.i_last = with_last && (i == m.size() - 1);
            @(negedge clk);
            while (!bus.i_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout byte=%0d got=stalled exp=accepted", i);
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_last = 1'b0;
    endtask

    task automatic wait_blocks(input int n, input string name);
        int t;
        t = 0;
        while (q.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (q.size() < n) begin
            bad++;
            $display("FAIL %s block_count got=%0d exp=%0d", name, q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.i_ready, bus.o_valid, bus.o_block, bus.o_first, bus.o_final, bus.o_len_err, bus.o_key_err}
            !== {1'b1, 1'b0, 512'h0, 4'b0000}) begin
            bad++;
            $display("FAIL reset got=%b/%b/%h exp=1/0/0", bus.i_ready, bus.o_valid, bus.o_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abc();
        logic [7:0] m[$];
        m = {8'h61, 8'h62, 8'h63};
        q.delete();
        send_bytes(m, 1'b1);
        total++;
        if (bus.o_valid !== 1'b1) begin
            bad++;
            $display("FAIL abc_latency got=%b exp=1", bus.o_valid);
        end
        wait_blocks(1, "abc");
        total++;
        if (q.size() >= 1 && q[0] !== {ABC, 1'b1, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL abc got=%h exp=%h", q[0], {ABC, 1'b1, 1'b1, 1'b0, KEY_EN});
        end
    endtask

    task automatic test_key33(input logic [7:0] hdr, input logic exp_kerr);
        logic [7:0] m[$];
        logic [515:0] exp;
        m = {hdr};
        for (int i = 1; i <= 32; i++) m.push_back(8'(i));
        exp = {hdr, 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20,
               8'h80, 176'h0, 64'h108, 1'b1, 1'b1, 1'b0, exp_kerr};
        q.delete();
        send_bytes(m, 1'b1);
        wait_blocks(1, "key33");
        total++;
        if (q.size() >= 1 && q[0] !== exp) begin
            bad++;
            $display("FAIL key33_%h got=%h exp=%h", hdr, q[0], exp);
        end
    endtask

    task automatic test_56();
        logic [7:0] m[$];
        logic [511:0] e1;
        e1 = '0;
        for (int i = 0; i < 56; i++) begin
            m.push_back(8'(i));
            e1[511-8*i -: 8] = 8'(i);
        end
        e1[511-8*56 -: 8] = 8'h80;
        q.delete();
        send_bytes(m, 1'b1);
        wait_blocks(2, "len56");
        total++;
        if (q.size() >= 2 && q[0] !== {e1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL len56_blk0 got=%h exp=%h", q[0], {e1, 4'b1000});
        end
        total++;
        if (q.size() >= 2 && q[1] !== {448'h0, 64'h1C0, 1'b0, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL len56_tail got=%h exp=%h", q[1], {448'h0, 64'h1C0, 1'b0, 1'b1, 1'b0, KEY_EN});
        end
    endtask

    task automatic test_key65();
        logic [7:0] m[$];
        logic [511:0] e1;
        m = {8'h04};
        e1 = '0;
        e1[511 -: 8] = 8'h04;
        for (int i = 1; i <= 64; i++) begin
            m.push_back(8'(i));
            if (i < 64) e1[511-8*i -: 8] = 8'(i);
        end
        q.delete();
        send_bytes(m, 1'b1);
        wait_blocks(2, "key65");
        total++;
        if (q.size() >= 2 && q[0] !== {e1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL key65_blk0 got=%h exp=%h", q[0], {e1, 4'b1000});
        end
        total++;
        if (q.size() >= 2 && q[1] !== {8'h40, 8'h80, 432'h0, 64'h208, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL key65_blk1 got=%h exp=%h", q[1], {8'h40, 8'h80, 432'h0, 64'h208, 4'b0100});
        end
    endtask

    task automatic test_64();
        logic [7:0] m[$];
        logic [511:0] e1;
        for (int i = 0; i < 64; i++) begin
            m.push_back(8'(i + 8'h40));
            e1[511-8*i -: 8] = 8'(i + 8'h40);
        end
        q.delete();
        send_bytes(m, 1'b1);
        wait_blocks(2, "len64");
        total++;
        if (q.size() >= 2 && q[0] !== {e1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL len64_blk0 got=%h exp=%h", q[0], {e1, 4'b1000});
        end
        total++;
        if (q.size() >= 2 && q[1] !== {8'h80, 440'h0, 64'h200, 1'b0, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL len64_tail got=%h exp=%h", q[1], {8'h80, 440'h0, 64'h200, 1'b0, 1'b1, 1'b0, KEY_EN});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] m[$];
        logic [511:0] e2;
        e2 = {24'h112280, 424'h0, 64'h10};
        m = {8'h61, 8'h62, 8'h63};
        q.delete();
        bus.o_ready = 1'b0;
        send_bytes(m, 1'b1);
        bus.i_valid = 1'b1;
        bus.i_data = 8'h11;
        bus.i_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({bus.o_valid, bus.i_ready, bus.o_block, bus.o_first, bus.o_final, bus.o_key_err}
                !== {2'b10, ABC, 2'b11, KEY_EN}) begin
                bad++;
                $display("FAIL stall_cycle%0d got=%b%b/%h exp=10/%h", c, bus.o_valid, bus.i_ready, bus.o_block, ABC);
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL stall_no_xfer got=%0d exp=0", q.size());
        end
        @(posedge clk);
        #1;
        bus.o_ready = 1'b1;
        m = {8'h11, 8'h22};
        send_bytes(m, 1'b1);
        wait_blocks(2, "stall");
        total++;
        if (q.size() >= 2 && q[0] !== {ABC, 1'b1, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL stall_blk0 got=%h exp=%h", q[0], {ABC, 1'b1, 1'b1, 1'b0, KEY_EN});
        end
        total++;
        if (q.size() >= 2 && q[1] !== {e2, 1'b1, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL stall_blk1 got=%h exp=%h", q[1], {e2, 1'b1, 1'b1, 1'b0, KEY_EN});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m[$];
        for (int i = 0; i < 20; i++) m.push_back(8'(8'hA0 + i));
        send_bytes(m, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.i_ready, bus.o_valid, bus.o_block, bus.o_first, bus.o_final, bus.o_len_err, bus.o_key_err}
            !== {1'b1, 1'b0, 512'h0, 4'b0000}) begin
            bad++;
            $display("FAIL mid_reset got=%b/%b/%h exp=1/0/0", bus.i_ready, bus.o_valid, bus.o_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_abc();
    endtask

    task automatic test_overflow();
        logic [7:0] m[$];
        for (int i = 0; i < 256; i++) m.push_back(8'(i));
        q.delete();
        send_bytes(m, 1'b1);
        wait_blocks(5, "overflow");
        total++;
        if (q.size() >= 5 && q[0].lerr !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early_err got=%b exp=0", q[0].lerr);
        end
        total++;
        if (q.size() >= 5 && q[4] !== {8'h80, 440'h0, 64'h7F8, 1'b0, 1'b1, 1'b1, KEY_EN}) begin
            bad++;
            $display("FAIL ovf_tail got=%h exp=%h", q[4], {8'h80, 440'h0, 64'h7F8, 1'b0, 1'b1, 1'b1, KEY_EN});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[$];
        q.delete();
        m = {8'h61, 8'h62, 8'h63};
        send_bytes(m, 1'b1);
        m = {8'h64, 8'h65};
        send_bytes(m, 1'b1);
        wait_blocks(2, "b2b");
        total++;
        if (q.size() >= 2 && q[0] !== {ABC, 1'b1, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL b2b_blk0 got=%h exp=%h", q[0], {ABC, 1'b1, 1'b1, 1'b0, KEY_EN});
        end
        total++;
        if (q.size() >= 2 && q[1] !== {24'h646580, 424'h0, 64'h10, 1'b1, 1'b1, 1'b0, KEY_EN}) begin
            bad++;
            $display("FAIL b2b_blk1 got=%h exp=%h", q[1], {24'h646580, 424'h0, 64'h10, 1'b1, 1'b1, 1'b0, KEY_EN});
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data = 8'h00;
        bus.i_last = 1'b0;
        bus.o_ready = 1'b1;
        test_reset();
        test_abc();
        test_key33(8'h02, 1'b0);
        test_key33(8'h05, KEY_EN);
        test_56();
        test_key65();
        test_64();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the Hash160 datapath (SHA-256 then RIPEMD-160).
- Accepts a variable-length message as a byte stream with valid/ready/last handshake.
- Applies FIPS 180-4 SHA-256 padding and emits big-endian 512-bit blocks to the SHA-256 core.
- Block 0 of each message is flagged so the core loads the IV; the last block is flagged so the core hands its digest to the RIPEMD-160 stage.

Parameters:
LEN_W, 16, width of the message byte counter; the maximum message length is 2^LEN_W-1 bytes.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input byte valid
i_ready  output  1  padder can accept a byte this cycle
i_data  input  8  message byte
i_last  input  1  qualifies i_data as the final byte of the message
o_valid  output  1  o_block holds a block
o_ready  input  1  SHA-256 core accepts the block
o_block  output  512  padded block; message byte 0 at [511:504]
o_first  output  1  o_block is the first block of a message
o_final  output  1  o_block is the last block of a message
o_len_err  output  1  message exceeded 2^LEN_W-1 bytes; valid with o_final
o_key_err  output  1  see Optional Feature

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0 except i_ready=1. State is S_FILL, byte index 0, length 0.
- A byte transfers when i_valid && i_ready. A block transfers when o_valid && o_ready.
- Every message is at least 1 byte long. i_last is ignored unless i_valid=1.
- States:
  - S_FILL: i_ready=1, o_valid=0. Each accepted byte is written at index idx (0..63). idx increments and the length counter increments.
  - S_EMIT: o_valid=1, i_ready=0. o_block, o_first, o_final and the error flags stay stable until the block transfers.
  - S_EMIT_TAIL: same as S_EMIT, but for a padding-only tail block.
- Exits from S_FILL:
  - Accepted byte with idx==63 and i_last=0: go to S_EMIT with o_final=0.
  - Accepted byte with i_last=1: let k = idx+1.
    - k<=55: in the same edge, write 0x80 at byte k, zeros at k+1..55, and the 64-bit big-endian bit length at bytes 56..63. Go to S_EMIT with o_final=1.
    - 56<=k<=63: write 0x80 at byte k and zeros at k+1..63. Go to S_EMIT with o_final=0 and a tail pending.
    - k==64: go to S_EMIT with o_final=0 and a tail pending. The tail block has 0x80 at byte 0.
- Tail block: zeros except as stated above, plus the bit length (= bytes*8) at bytes 56..63. Emitted from S_EMIT_TAIL with o_final=1.
- Transitions on block transfer:
  - From S_EMIT with a tail pending: go to S_EMIT_TAIL, with o_valid staying high and the new block presented the next cycle.
  - Otherwise: go to S_FILL with idx=0.
  - After an o_final block transfers: clear the length counter, the error flags, and the first flag.
- Latency: o_valid rises on the cycle after the accepting edge of byte 63 or of the last byte.
- o_first=1 on the first block after S_FILL entry with length 0, and 0 on all later blocks.
- Length overflow: the counter saturates at 2^LEN_W-1 and sets sticky o_len_err. Padding still completes using the saturated length.
- Reset mid-message discards the partial block, the length, and any pending tail.
- The buffer for byte positions not yet written in a new block is cleared on block transfer.

Optional Feature:
- Macro HASH160_PUBKEY_CHECK_EN.
- When defined: o_key_err is asserted, stable with the final block, if the message is not a valid SEC public key. Valid keys are 33 bytes with first byte 0x02 or 0x03, or 65 bytes with first byte 0x04. The flag clears after the final block transfers. Padding is unaffected.
- When undefined: o_key_err is tied to 0 and no check logic is built.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), o_ready=1 -> one block 0x61626380 followed by zeros with final bytes 0x...0018; o_first=1, o_final=1, o_valid rises 1 cycle after the last-byte edge.
- 33-byte key 0x02,0x01..0x20 -> one block, byte33=0x80, bytes 56..63=0x0000000000000108, o_first=o_final=1. With macro: o_key_err=0. With first byte 0x05: o_key_err=1.
- 56-byte message -> block 1: byte56=0x80, o_final=0. Block 2: all zeros except 0x...01C0, o_first=0, o_final=1.
- 65-byte key 0x04,... -> block 1: 64 data bytes. Block 2: byte0=last byte, byte1=0x80, length 0x0208. 64-byte message -> tail byte0=0x80, length 0x0200.
- o_ready=0 for 10 cycles during S_EMIT -> o_block/flags stable, i_ready=0, next held byte accepted only after the transfer, no byte lost or duplicated.
- Assert rst_n after 20 bytes -> outputs return to reset values immediately. A following "abc" yields the same block as scenario 1.
